// File: rtl/fifo_pkg.sv
// Shared FIFO parameters and the request encoding used by the pointer/counter logic.
package fifo_pkg;

    localparam int unsigned ADDR_W_DEF    = 4;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned AFULL_LVL_DEF = 12;
    localparam int unsigned DEPTH_DEF     = 1 << ADDR_W_DEF;
    localparam int unsigned CNT_W_DEF     = ADDR_W_DEF + 1;

    // Accepted-request pair {push_ok, pop_ok}; decides how count moves.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    function automatic op_e op_of(input logic push_ok, input logic pop_ok);
        return op_e'({push_ok, pop_ok});
    endfunction

endpackage

// File: rtl/memory.sv
// Two-port block RAM: synchronous write, registered read enabled by r_en.
module memory
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
        if (r_en) begin
            r_data <= mem[r_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: fifo_ctrl plus the two-port RAM behind a push/pop interface.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned AFULL_LVL = AFULL_LVL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              r_en;
    logic [ADDR_W-1:0] r_addr;

    fifo_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .AFULL_LVL (AFULL_LVL)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .pop_valid   (pop_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .mem_w_en    (w_en),
        .mem_w_addr  (w_addr),
        .mem_w_data  (w_data),
        .mem_r_en    (r_en),
        .mem_r_addr  (r_addr)
    );

    memory #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk    (clk),
        .w_en   (w_en),
        .w_addr (w_addr),
        .w_data (w_data),
        .r_en   (r_en),
        .r_addr (r_addr),
        .r_data (pop_data)
    );

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/count/flag controller that drives a two-port RAM as a synchronous FIFO.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned AFULL_LVL = AFULL_LVL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;
    logic [CNT_W-1:0]  count_next;
    op_e               op;

    // Accept decisions use only registered flags, so push+pop never collide on one address.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign op      = op_of(push_ok, pop_ok);

    assign mem_w_en   = push_ok;
    assign mem_w_addr = wr_ptr;
    assign mem_w_data = push_data;
    assign mem_r_en   = pop_ok;
    assign mem_r_addr = rd_ptr;

    always_comb begin
        count_next = count;
        unique case (op)
            OP_PUSH: count_next = count + CNT_W'(1);
            OP_POP:  count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Pointers wrap naturally at DEPTH via their ADDR_W width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + ADDR_W'(push_ok);
            rd_ptr <= rd_ptr + ADDR_W'(pop_ok);
        end
    end

    // Flags come from count_next so they change in the same cycle as count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
        end else begin
            count       <= count_next;
            full        <= (count_next == CNT_W'(DEPTH));
            empty       <= (count_next == '0);
            almost_full <= (count_next >= CNT_W'(AFULL_LVL));
        end
    end

    // pop_valid marks the cycle the RAM's registered read holds the popped word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= pop_ok;
            overflow  <= overflow | (push & full);
            underflow <= underflow | (pop & empty);
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl driving a RAM: directed vector table, hand sequences and random traffic vs a queue model.
module tb_fifo_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned AF    = 12;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          pop = 1'b0;
    logic          pop_valid, full, empty, almost_full, overflow, underflow;
    logic [AW:0]   count;
    logic          mem_w_en, mem_r_en;
    logic [AW-1:0] mem_w_addr, mem_r_addr;
    logic [DW-1:0] mem_w_data, r_data;

    fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW), .AFULL_LVL(AF)) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .pop_valid   (pop_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .mem_w_en    (mem_w_en),
        .mem_w_addr  (mem_w_addr),
        .mem_w_data  (mem_w_data),
        .mem_r_en    (mem_r_en),
        .mem_r_addr  (mem_r_addr)
    );

    memory #(.ADDR_W(AW), .DATA_W(DW)) ram (
        .clk    (clk),
        .w_en   (mem_w_en),
        .w_addr (mem_w_addr),
        .w_data (mem_w_data),
        .r_en   (mem_r_en),
        .r_addr (mem_r_addr),
        .r_data (r_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       push;
        bit [7:0] data;
        bit       pop;
        int       cnt;
        bit       full;
        bit       empty;
        bit       af;
        bit       ovf;
        bit       unf;
        bit       wen;
        bit       ren;
        bit       pv;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic [7:0] sb[$];
    logic [3:0] m_wr = '0;
    logic [3:0] m_rd = '0;
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit p, input bit [7:0] d, input bit q, input int cnt,
                                input bit f, input bit e, input bit a, input bit o, input bit u,
                                input bit we, input bit re, input bit pv);
        vec_t v;
        v.push = p; v.data = d; v.pop = q; v.cnt = cnt;
        v.full = f; v.empty = e; v.af = a; v.ovf = o; v.unf = u;
        v.wen = we; v.ren = re; v.pv = pv;
        return v;
    endfunction

    function automatic vec_t in(input bit p, input bit [7:0] d, input bit q);
        return mk(p, d, q, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_wr  = '0;
        m_rd  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock of stimulus; model checks always, table expectations when use_exp is set.
    task automatic step(input vec_t v, input bit use_exp);
        bit         wok, pok;
        logic [7:0] exp_d;
        @(negedge clk);
        push = v.push; push_data = v.data; pop = v.pop;
        #1;
        wok = v.push && (mq.size() < DEPTH);
        pok = v.pop && (mq.size() > 0);
        chk("mem_w_en", mem_w_en, wok);
        chk("mem_r_en", mem_r_en, pok);
        chk("mem_w_addr", mem_w_addr, m_wr);
        chk("mem_r_addr", mem_r_addr, m_rd);
        chk("mem_w_data", mem_w_data, v.data);
        if (use_exp) begin
            chk("tbl_w_en", mem_w_en, v.wen);
            chk("tbl_r_en", mem_r_en, v.ren);
        end
        @(posedge clk);
        #1;
        if (v.push && !wok) m_ovf = 1'b1;
        if (v.pop && !pok)  m_unf = 1'b1;
        if (pok) begin
            sb.push_back(mq.pop_front());
            m_rd = m_rd + 4'd1;
        end
        if (wok) begin
            mq.push_back(v.data);
            m_wr = m_wr + 4'd1;
        end
        chk("count", count, mq.size());
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("almost_full", almost_full, mq.size() >= AF);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
        chk("pop_valid", pop_valid, pok);
        if (pok) begin
            exp_d = sb.pop_front();
            if (pop_valid) chk("r_data", r_data, exp_d);
        end
        if (use_exp) begin
            chk("tbl_count", count, v.cnt);
            chk("tbl_full", full, v.full);
            chk("tbl_empty", empty, v.empty);
            chk("tbl_af", almost_full, v.af);
            chk("tbl_ovf", overflow, v.ovf);
            chk("tbl_unf", underflow, v.unf);
            chk("tbl_pv", pop_valid, v.pv);
        end
    endtask

    initial begin
        int pp;
        // Directed table: fill to full, overflow, drain, underflow, push+pop while empty
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1, 8'(8'h11 + i), 0, i + 1, i == 15, 0, i >= 11, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 8'hAA, 0, 16, 1, 0, 1, 1, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 8'h00, 1, 15 - i, 0, i == 15, i <= 3, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h5A, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 1, 1, 0, 1, 1));

        #1 rst = 1'b1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_pv", pop_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        chk("rst_w_addr", mem_w_addr, 0);
        chk("rst_r_addr", mem_r_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) step(vecs[i], 1'b1);

        // Fill to 8, then steady push+pop across the pointer wrap
        for (int i = 0; i < 8; i++) step(in(1, 8'(8'h60 + i), 0), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(in(1, 8'(8'h80 + i), 1), 1'b0);
            chk("hold_count", count, 8);
        end

        // Drain to 5, then reset with a pop in flight
        for (int i = 0; i < 3; i++) step(in(0, 8'h00, 1), 1'b0);
        chk("pre_rst_count", count, 5);
        @(negedge clk);
        pop = 1'b1; push = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_af", almost_full, 0);
        chk("mid_rst_pv", pop_valid, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_unf", underflow, 0);
        chk("mid_rst_r_en", mem_r_en, 0);
        chk("mid_rst_r_addr", mem_r_addr, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0; pop = 1'b0;
        step(in(1, 8'h3C, 0), 1'b0);
        step(in(0, 8'h00, 1), 1'b0);
        chk("post_rst_data", r_data, 8'h3C);
        step(in(0, 8'h00, 0), 1'b0);

        // Random traffic with a drifting push/pop bias to reach full and empty
        pp = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 400 == 0) pp = int'($urandom_range(15, 85));
            step(in($urandom_range(0, 99) < pp, 8'($urandom), $urandom_range(0, 99) < (100 - pp)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
